// File: rtl/seq_divider_if.sv
// Operand/result bundle for seq_divider: the requester drives the operands and
// start strobe, the divider returns registered results and status.
interface seq_divider_if #(
  parameter int N = 4
);
  logic             start;
  logic [2*N-1:0]   dividend;
  logic [N-1:0]     divisor;
  logic [2*N-1:0]   quotient;
  logic [N-1:0]     remainder;
  logic             op_ready;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, op_ready, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, op_ready, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider, unsigned 2N/N, one quotient bit per clock.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   BUSY  | shifting/subtracting, 2N iterations
//   DONE  | results held, op_ready high
module seq_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);
  localparam int W  = 2 * N;
  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_n;
  logic [W-1:0]    q, q_n;
  logic [N-1:0]    r, r_n;
  logic [N-1:0]    d, d_n;
  logic [CW-1:0]   count, count_n;
  logic [W-1:0]    quot, quot_n;
  logic [N-1:0]    rem, rem_n;
  logic            dbz, dbz_n;
  logic [N:0]      s;
  logic [N:0]      diff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q     <= '0;
      r     <= '0;
      d     <= '0;
      count <= '0;
      quot  <= '0;
      rem   <= '0;
      dbz   <= 1'b0;
    end else begin
      state <= state_n;
      q     <= q_n;
      r     <= r_n;
      d     <= d_n;
      count <= count_n;
      quot  <= quot_n;
      rem   <= rem_n;
      dbz   <= dbz_n;
    end
  end

  // The partial remainder stays below D, so S - D fits in N+1 bits and its
  // top bit is exactly the borrow: set means S < D.
  always_comb begin
    state_n = state;
    q_n     = q;
    r_n     = r;
    d_n     = d;
    count_n = count;
    quot_n  = quot;
    rem_n   = rem;
    dbz_n   = dbz;
    s       = {r, q[W-1]};
    diff    = s - {1'b0, d};

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            state_n = DONE;
            quot_n  = '1;
            rem_n   = '0;
            dbz_n   = 1'b1;
          end else begin
            state_n = BUSY;
            q_n     = bus.dividend;
            r_n     = '0;
            d_n     = bus.divisor;
            count_n = '0;
          end
        end
      end
      BUSY: begin
        if (!diff[N]) begin
          r_n = diff[N-1:0];
          q_n = {q[W-2:0], 1'b1};
        end else begin
          r_n = s[N-1:0];
          q_n = {q[W-2:0], 1'b0};
        end
        count_n = count + CW'(1);
        if (count == LAST) begin
          state_n = DONE;
          quot_n  = q_n;
          rem_n   = r_n;
          dbz_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // dbz is held like the results; the flag is only shown while in DONE.
  assign bus.quotient    = quot;
  assign bus.remainder   = rem;
  assign bus.op_ready    = (state == DONE);
  assign bus.div_by_zero = dbz && (state == DONE);
endmodule

// File: tb/tb_seq_divider.sv
// Directed checks for seq_divider (N=4): latency, results, divide-by-zero,
// busy-start immunity, reset abort and an exhaustive back-to-back sweep.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.N(4)) bus ();

  seq_divider #(.N(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Wait for op_ready with a bound; cyc is the cycle index counted from the start cycle.
  task automatic wait_ready(inout int cyc);
    while (!bus.op_ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_res(input logic [7:0] eq, input logic [3:0] er, input logic ez);
    chk("op_ready", {31'd0, bus.op_ready}, 32'd1);
    chk("quotient", {24'd0, bus.quotient}, {24'd0, eq});
    chk("remainder", {28'd0, bus.remainder}, {28'd0, er});
    chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, ez});
  endtask

  task automatic run_op(input logic [7:0] dvd, input logic [3:0] dvs,
                        input logic [7:0] eq, input logic [3:0] er,
                        input logic ez, input int lat);
    int cyc;
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = ~dvd;
    bus.divisor  = ~dvs;
    cyc = 1;
    if (lat > 1) begin
      chk("ready_drop", {31'd0, bus.op_ready}, 32'd0);
      chk("dbz_drop", {31'd0, bus.div_by_zero}, 32'd0);
    end
    wait_ready(cyc);
    chk("latency", cyc, lat);
    check_res(eq, er, ez);
  endtask

  initial begin
    int cyc;
    int highs;
    logic [7:0] sq;
    logic [3:0] sr;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    tick(3);
    rst = 1'b0;
    chk("rst_quotient", {24'd0, bus.quotient}, 32'd0);
    chk("rst_remainder", {28'd0, bus.remainder}, 32'd0);
    chk("rst_ready", {31'd0, bus.op_ready}, 32'd0);
    chk("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    tick(2);

    run_op(8'h18, 4'h8, 8'h03, 4'h0, 1'b0, 9);
    run_op(8'd63, 4'd9, 8'd7, 4'd0, 1'b0, 9);
    run_op(8'd77, 4'd7, 8'd11, 4'd0, 1'b0, 9);
    run_op(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 9);
    run_op(8'd200, 4'd15, 8'd13, 4'd5, 1'b0, 9);

    run_op(8'h5A, 4'h0, 8'hFF, 4'h0, 1'b1, 1);
    run_op(8'h5A, 4'h3, 8'h1E, 4'h0, 1'b0, 9);

    // second start while busy must be ignored
    bus.start = 1'b1; bus.dividend = 8'h18; bus.divisor = 4'h8;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    tick(3);
    cyc += 3;
    bus.start = 1'b1; bus.dividend = 8'hFF; bus.divisor = 4'h1;
    @(negedge clk);
    cyc++;
    bus.start = 1'b0;
    chk("busy_ready", {31'd0, bus.op_ready}, 32'd0);
    wait_ready(cyc);
    chk("busy_latency", cyc, 9);
    check_res(8'h03, 4'h0, 1'b0);
    tick(5);
    chk("ready_held", {31'd0, bus.op_ready}, 32'd1);
    chk("quot_held", {24'd0, bus.quotient}, 32'd3);

    // reset in busy cycle 5 aborts the op
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd15;
    @(negedge clk);
    bus.start = 1'b0;
    tick(4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_quotient", {24'd0, bus.quotient}, 32'd0);
    chk("abort_remainder", {28'd0, bus.remainder}, 32'd0);
    chk("abort_ready", {31'd0, bus.op_ready}, 32'd0);
    chk("abort_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.op_ready) highs++;
    end
    chk("abort_no_ready", highs, 0);
    run_op(8'd77, 4'd7, 8'd11, 4'd0, 1'b0, 9);

    // exhaustive sweep, each op launched in the first DONE cycle
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        sq = 8'(a / b);
        sr = 4'(a % b);
        run_op(8'(a), 4'(b), sq, sr, 1'b0, 9);
        chk("identity", 32'(bus.quotient) * 32'(b) + 32'(bus.remainder), 32'(a));
        chk("rem_lt_div", {31'd0, (32'(bus.remainder) < 32'(b))}, 32'd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
